// File: rtl/he_pkg.sv
// rtl/he_pkg.sv - shared state type and sizing helpers for the histogram-equalisation engine
`timescale 1ns/1ps
package he_pkg;

  typedef enum logic [2:0] {
    S_HIST = 3'd0,
    S_CDF  = 3'd1,
    S_LUT  = 3'd2,
    S_OUT  = 3'd3,
    S_CLR  = 3'd4
  } he_state_t;

  function automatic int he_clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  function automatic int he_num_bins(input int pix_w);
    return 1 << pix_w;
  endfunction

  function automatic int he_lmax(input int pix_w);
    return (1 << pix_w) - 1;
  endfunction

  // Counters must hold the full pixel count N, hence N+1 states.
  function automatic int he_cnt_w(input int n);
    return he_clog2(n + 1);
  endfunction

endpackage

// File: rtl/he_divider.sv
// rtl/he_divider.sv - restoring sequential divider, one quotient bit per cycle
`timescale 1ns/1ps
module he_divider
  import he_pkg::*;
#(
  parameter int NUM_W = 12,
  parameter int DEN_W = 4,
  parameter int Q_W   = NUM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [NUM_W-1:0] i_num,
  input  logic [DEN_W-1:0] i_den,
  output logic             o_busy,
  output logic             o_done_q,
  output logic [Q_W-1:0]   o_quotient
);

  localparam int STEP_W = he_clog2(NUM_W + 1);

  logic [STEP_W-1:0] r_steps;
  logic [NUM_W-1:0]  r_quo;
  logic [DEN_W-1:0]  r_rem;
  logic [DEN_W-1:0]  r_den;
  logic              r_busy;
  logic              r_done;

  logic [DEN_W:0] w_shift;
  logic [DEN_W:0] w_diff;
  logic           w_ge;

  // Remainder stays below the divisor, so one extra bit covers the shifted value.
  assign w_shift = {r_rem, r_quo[NUM_W-1]};
  assign w_diff  = w_shift - {1'b0, r_den};
  assign w_ge    = (w_shift >= {1'b0, r_den});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_steps <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_den   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_quo   <= i_num;
        r_rem   <= '0;
        r_den   <= i_den;
        r_steps <= STEP_W'(NUM_W);
        r_busy  <= 1'b1;
      end else if (r_busy) begin
        r_rem   <= w_ge ? w_diff[DEN_W-1:0] : w_shift[DEN_W-1:0];
        r_quo   <= {r_quo[NUM_W-2:0], w_ge};
        r_steps <= r_steps - STEP_W'(1);
        if (r_steps == STEP_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done_q   = r_done;
  assign o_quotient = r_quo[Q_W-1:0];

endmodule

// File: rtl/he_stream.sv
// rtl/he_stream.sv - streaming histogram-equalisation engine: buffer frame, build CDF/LUT, stream remapped frame
`timescale 1ns/1ps
module he_stream
  import he_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 660,
  parameter int IMG_H = 440
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode_min_norm,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_last,
  output logic             done
);

  localparam int NUM_BINS = he_num_bins(PIX_W);
  localparam int LMAX     = he_lmax(PIX_W);
  localparam int N        = IMG_W * IMG_H;
  localparam int CNT_W    = he_cnt_w(N);
  localparam int IDX_W    = (N > 1) ? he_clog2(N) : 1;
  localparam int NUM_W    = CNT_W + PIX_W;

  localparam logic [CNT_W-1:0] C_N    = CNT_W'(N);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);
  localparam logic [PIX_W-1:0] C_LMAX = PIX_W'(LMAX);

  he_state_t r_state;
  he_state_t w_next;

  logic [CNT_W-1:0] r_hist [NUM_BINS];
  logic [PIX_W-1:0] r_fbuf [N];
  logic [PIX_W-1:0] r_lut  [NUM_BINS];

  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_rd_idx;
  logic [CNT_W-1:0] r_sum;
  logic [CNT_W-1:0] r_cdf_min;
  logic [PIX_W-1:0] r_bin;
  logic [PIX_W-1:0] r_fb_q;
  logic [PIX_W-1:0] r_out_pixel;
  logic             r_min_found;
  logic             r_mode;
  logic             r_lut_wait;
  logic             r_s1_valid;
  logic             r_s1_last;
  logic             r_out_valid;
  logic             r_out_last;

  logic             w_accept;
  logic             w_bin_last;
  logic [CNT_W-1:0] w_cdf;
  logic [CNT_W-1:0] w_cdf_b;
  logic             w_identity;
  logic             w_below;
  logic [CNT_W-1:0] w_num_diff;
  logic [NUM_W-1:0] w_num;
  logic [CNT_W-1:0] w_den;
  logic             w_div_start;
  logic             w_div_busy;
  logic             w_div_done;
  logic [PIX_W-1:0] w_quot;
  logic             w_lut_we;
  logic [PIX_W-1:0] w_lut_wdata;
  logic             w_out_fire;
  logic             w_out_adv;
  logic             w_s1_free;
  logic             w_rd_en;
  logic             w_last_rd;

  assign in_ready   = (r_state == S_HIST) && !reset;
  assign w_accept   = in_valid && in_ready;
  assign w_bin_last = (r_bin == C_LMAX);

  // hist is rewritten in place with the running CDF, so S_LUT reads cdf[b] from it.
  assign w_cdf      = r_sum + r_hist[r_bin];
  assign w_cdf_b    = r_hist[r_bin];
  assign w_identity = r_mode && (r_cdf_min == C_N);
  assign w_below    = (w_cdf_b < r_cdf_min);
  assign w_num_diff = r_mode ? (w_below ? '0 : (w_cdf_b - r_cdf_min)) : w_cdf_b;
  assign w_num      = NUM_W'(LMAX) * NUM_W'(w_num_diff);
  assign w_den      = r_mode ? (C_N - r_cdf_min) : C_N;

  assign w_out_fire = r_out_valid && out_ready;
  assign w_out_adv  = !r_out_valid || out_ready;
  assign w_s1_free  = !r_s1_valid || w_out_adv;
  assign w_last_rd  = (r_rd_idx == C_LAST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_HIST;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_div_start = 1'b0;
    w_lut_we    = 1'b0;
    w_lut_wdata = r_bin;
    w_rd_en     = 1'b0;
    case (r_state)
      S_HIST: if (w_accept && (r_idx == C_LAST)) w_next = S_CDF;
      S_CDF:  if (w_bin_last) w_next = S_CDF == S_CDF ? S_LUT : S_LUT;
      S_LUT: begin
        if (r_lut_wait) begin
          if (w_div_done) begin
            w_lut_we    = 1'b1;
            w_lut_wdata = w_quot;
          end
        end else if (w_identity) begin
          w_lut_we = 1'b1;
        end else if (!w_div_busy) begin
          w_div_start = 1'b1;
        end
        if (w_lut_we && w_bin_last) w_next = S_OUT;
      end
      S_OUT: begin
        w_rd_en = (r_rd_idx != C_N) && w_s1_free;
        if (w_out_fire && r_out_last) w_next = S_CLR;
      end
      S_CLR:  if (w_bin_last) w_next = S_HIST;
      default: w_next = S_HIST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BINS; b++) r_hist[b] <= '0;
      r_idx       <= '0;
      r_rd_idx    <= '0;
      r_sum       <= '0;
      r_cdf_min   <= '0;
      r_bin       <= '0;
      r_min_found <= 1'b0;
      r_mode      <= 1'b0;
      r_lut_wait  <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_pixel <= '0;
    end else begin
      case (r_state)
        S_HIST: begin
          if (w_accept) begin
            r_hist[in_pixel] <= r_hist[in_pixel] + CNT_W'(1);
            r_idx            <= r_idx + CNT_W'(1);
            if (r_idx == '0) r_mode <= mode_min_norm;
          end
        end
        S_CDF: begin
          r_hist[r_bin] <= w_cdf;
          r_sum         <= w_cdf;
          if (!r_min_found && (w_cdf != '0)) begin
            r_min_found <= 1'b1;
            r_cdf_min   <= w_cdf;
          end
          r_bin <= r_bin + PIX_W'(1);
        end
        S_LUT: begin
          if (w_div_start) r_lut_wait <= 1'b1;
          if (w_lut_we) begin
            r_lut_wait <= 1'b0;
            r_bin      <= r_bin + PIX_W'(1);
          end
        end
        S_OUT: begin
          // Two-stage read pipeline (fbuf, then lut) that stalls as a unit on backpressure.
          if (w_rd_en) r_rd_idx <= r_rd_idx + CNT_W'(1);
          if (w_s1_free) begin
            r_s1_valid <= w_rd_en;
            r_s1_last  <= w_rd_en && w_last_rd;
          end
          if (w_out_adv) begin
            r_out_valid <= r_s1_valid;
            r_out_last  <= r_s1_last;
            if (r_s1_valid) r_out_pixel <= r_lut[r_fb_q];
          end
        end
        S_CLR: begin
          r_hist[r_bin] <= '0;
          r_bin         <= r_bin + PIX_W'(1);
          r_idx         <= '0;
          r_rd_idx      <= '0;
          r_sum         <= '0;
          r_cdf_min     <= '0;
          r_min_found   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_fbuf[r_idx[IDX_W-1:0]] <= in_pixel;
    if (w_rd_en)  r_fb_q <= r_fbuf[r_rd_idx[IDX_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (w_lut_we) r_lut[r_bin] <= w_lut_wdata;
  end

  he_divider #(
    .NUM_W (NUM_W),
    .DEN_W (CNT_W),
    .Q_W   (PIX_W)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_div_start),
    .i_num      (w_num),
    .i_den      (w_den),
    .o_busy     (w_div_busy),
    .o_done_q   (w_div_done),
    .o_quotient (w_quot)
  );

  assign out_valid = r_out_valid;
  assign out_pixel = r_out_pixel;
  assign out_last  = r_out_last;
  assign done      = w_out_fire && r_out_last && !reset;

endmodule

// File: tb/tb_he_stream.sv
// tb/tb_he_stream.sv - randomized scoreboard bench for he_stream with a count-based equalisation model
`timescale 1ns/1ps
module tb_he_stream;

  localparam int PIX_W    = 8;
  localparam int IMG_W    = 4;
  localparam int IMG_H    = 2;
  localparam int N        = IMG_W * IMG_H;
  localparam int NUM_BINS = 256;
  localparam int LMAX     = 255;

  logic             clk = 1'b0;
  logic             reset;
  logic             mode_min_norm;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixel;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_pixel;
  logic             out_last;
  logic             done;

  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  int popped   = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int exp_pix[$];
  bit exp_last[$];
  bit ready_toggle = 1'b0;
  bit ready_rand   = 1'b0;
  logic mon_fire;
  logic mon_exp_done;

  int fa[N]   = '{0, 0, 0, 0, 255, 255, 255, 255};
  int f100[N] = '{100, 100, 100, 100, 100, 100, 100, 100};
  int fb[N]   = '{10, 20, 30, 40, 50, 60, 70, 80};
  int rf[N];

  he_stream #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk           (clk),
    .reset         (reset),
    .mode_min_norm (mode_min_norm),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pixel      (in_pixel),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pixel     (out_pixel),
    .out_last      (out_last),
    .done          (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Equalised value from counts: pixels <= p, and how many share the frame minimum.
  function automatic int model_pix(input int f[N], input int p, input bit mn);
    int le;
    int lo;
    int cmin;
    le = 0; lo = LMAX; cmin = 0;
    foreach (f[i]) begin
      if (f[i] <= p) le++;
      if (f[i] < lo) lo = f[i];
    end
    foreach (f[i]) if (f[i] == lo) cmin++;
    if (!mn) return (LMAX * le) / N;
    if (cmin == N) return p;
    return (LMAX * (le - cmin)) / (N - cmin);
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      mon_fire     = out_valid && out_ready;
      mon_exp_done = mon_fire && (exp_pix.size() > 0) && exp_last[0];
      check("done", done, mon_exp_done);
      if (out_valid) begin
        if (exp_pix.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got pixel %0d, scoreboard empty", out_pixel);
        end else begin
          check("out_pixel", out_pixel, exp_pix[0]);
          check("out_last", out_last, exp_last[0]);
          if (out_ready) begin
            void'(exp_pix.pop_front());
            void'(exp_last.pop_front());
            popped++;
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_toggle)    out_ready = ~out_ready;
      else if (ready_rand) out_ready = 1'($urandom_range(0, 1));
      else                 out_ready = 1'b1;
    end
  end

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    exp_pix.delete();
    exp_last.delete();
    repeat (n) begin
      @(negedge clk);
      check("in_ready_in_reset", in_ready, 0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pixel", out_pixel, 0);
    check("rst_out_last", out_last, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 1);
  endtask

  task automatic send_frame(input int f[N], input bit mn, input int max_gap);
    int gap;
    bit accepted;
    @(posedge clk);
    #1;
    mode_min_norm = mn;
    for (int i = 0; i < N; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_pixel = PIX_W'(f[i]);
      accepted = 1'b0;
      for (int t = 0; t < 3000 && !accepted; t++) begin
        @(negedge clk);
        if (in_ready) accepted = 1'b1;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      if (!accepted) begin
        checks++;
        errors++;
        $display("FAIL input_accept: pixel %0d not accepted within budget", i);
        return;
      end
    end
    for (int i = 0; i < N; i++) begin
      exp_pix.push_back(model_pix(f, f[i], mn));
      exp_last.push_back(i == N - 1);
    end
    @(negedge clk);
    check("in_ready_drop", in_ready, 0);
  endtask

  task automatic wait_done(input int budget);
    int start;
    int hi;
    start = done_cnt;
    hi = 0;
    for (int t = 0; t < budget && done_cnt == start; t++) begin
      @(negedge clk);
      if (in_ready && done_cnt == start) hi++;
    end
    check("in_ready_busy", hi, 0);
    check("done_seen", done_cnt - start, 1);
  endtask

  task automatic wait_rearm();
    bit found;
    found = 1'b0;
    for (int t = 0; t < 1000 && !found; t++) begin
      @(negedge clk);
      if (in_ready) found = 1'b1;
    end
    check("rearm_delay", cyc - done_cyc, NUM_BINS + 1);
  endtask

  task automatic run_frame(input int f[N], input bit mn, input int max_gap);
    send_frame(f, mn, max_gap);
    wait_done(8000);
    wait_rearm();
    check("scoreboard_drained", exp_pix.size(), 0);
  endtask

  initial begin
    int p0;
    reset         = 1'b1;
    in_valid      = 1'b0;
    in_pixel      = '0;
    mode_min_norm = 1'b0;
    do_reset(2);

    run_frame(fa, 1'b0, 0);
    run_frame(fa, 1'b1, 0);
    run_frame(f100, 1'b1, 0);
    run_frame(f100, 1'b0, 0);

    ready_toggle = 1'b1;
    for (int i = 0; i < N; i++) rf[i] = int'($urandom_range(0, 255));
    run_frame(rf, 1'b0, 3);
    ready_toggle = 1'b0;

    send_frame(fa, 1'b0, 0);
    p0 = popped;
    for (int t = 0; t < 8000 && popped < p0 + 3; t++) @(negedge clk);
    check("pre_reset_pops", popped - p0, 3);
    do_reset(1);
    run_frame(fb, 1'b0, 0);
    run_frame(fb, 1'b0, 0);

    ready_rand = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++)
        rf[i] = (k == 1) ? int'($urandom_range(0, 3)) * 85 : int'($urandom_range(0, 255));
      run_frame(rf, 1'($urandom_range(0, 1)), 2);
    end
    ready_rand = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/he_stream.md
# he_stream

Parametrised streaming histogram-equalisation engine: accepts one IMG_W×IMG_H greyscale frame over a valid/ready input, stores it in an internal frame buffer while building the histogram, then computes CDF and LUT. It streams the equalised frame out over a valid/ready output and re-arms for the next frame. It sits between the pixel source and the downstream display/writeback path.

## Interface
- PIX_W, 8: pixel width; NUM_BINS = 2^PIX_W, LMAX = NUM_BINS-1
- IMG_W, 660: frame width in pixels
- IMG_H, 440: frame height in pixels; N = IMG_W*IMG_H, CNT_W = clog2(N+1)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- mode_min_norm  in  1  0 = classic, 1 = cdf_min-normalised; sampled when the first pixel of a frame is accepted
- in_valid  in  1  input pixel valid
- in_ready  out  1  high only in S_HIST
- in_pixel  in  PIX_W  input pixel
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accept
- out_pixel  out  PIX_W  equalised pixel
- out_last  out  1  high with the N-th output pixel
- done  out  1  one-cycle pulse on the cycle the N-th output pixel is accepted

## Operation
- States: S_HIST → S_CDF → S_LUT → S_OUT → S_CLR → S_HIST.
- S_HIST: each in_valid&&in_ready cycle writes in_pixel to fbuf[idx], increments hist[in_pixel], idx++. After the N-th accept, go to S_CDF. No other exit.
- S_CDF: NUM_BINS cycles, bin 0..LMAX in order. Running sum cdf[b] = cdf[b-1] + hist[b]. cdf_min = first nonzero cdf value.
- S_LUT: per bin, start he_divider and write the quotient to lut[b].
  - Classic: lut[b] = floor(LMAX*cdf[b] / N).
  - Min-norm: lut[b] = floor(LMAX*(cdf[b]-cdf_min) / (N-cdf_min)). If cdf[b] < cdf_min, the numerator is 0.
  - Min-norm with N-cdf_min == 0 (single-valued frame): lut[b] = b (identity); the divider is skipped.
- Widths:
  - hist and cdf: CNT_W bits, cannot overflow.
  - Numerator: CNT_W+PIX_W bits.
  - Quotient ≤ LMAX, truncated to PIX_W bits with no loss.
- S_OUT: read fbuf[0..N-1] in order and emit lut[fbuf[k]]. out_last is high with k = N-1. Exit to S_CLR after that pixel is accepted.
- S_CLR: zero hist over NUM_BINS cycles, idx = 0, then S_HIST.
- reset (any state, including mid-frame or mid-output):
  - state = S_HIST; hist, idx, cdf_min and the divider are cleared in that cycle.
  - Partial frames are discarded.
  - fbuf and lut contents are don't-care.

## Timing
- Reset values: in_ready=0 during the reset cycle and 1 on the following cycle; out_valid=0, out_pixel=0, out_last=0, done=0.
- Input accepts at up to 1 pixel/cycle.
- in_ready drops in the cycle after the N-th accept.
- S_CDF takes exactly NUM_BINS cycles.
- S_LUT takes at most NUM_BINS*(CNT_W+PIX_W+2) cycles.
- First out_valid occurs exactly 2 cycles after entering S_OUT: fbuf read, then lut read (registered output).
- Output throughput is 1 pixel/cycle while out_ready=1.
- While out_valid && !out_ready, out_pixel and out_last hold stable and no pixel is skipped or duplicated.
- out_valid never deasserts without a handshake, except on reset.
- done rises in the same cycle as the final out_valid&&out_ready.
- S_CLR takes NUM_BINS cycles.
- in_ready reasserts NUM_BINS+1 cycles after done.

## Structure
- Shared package he_pkg:
  - state encoding localparams (S_HIST..S_CLR)
  - clog2 function
  - derived constants NUM_BINS, LMAX, CNT_W
- Sub-module he_divider: restoring sequential divider.
  - Parameters: NUM_W, DEN_W.
  - Handshake: start/busy/done_q.
  - Output: quotient, one bit per cycle.
- Storage: fbuf (N×PIX_W) and lut (NUM_BINS×PIX_W) as single-port RAM-inferable arrays; hist as a register array with synchronous clear.

## Test plan
Parameters for all scenarios: PIX_W=8, IMG_W=4, IMG_H=2 (N=8).
- Reset: assert reset 2 cycles → out_valid=0, out_pixel=0, out_last=0, done=0; in_ready=1 on the first cycle after reset deasserts.
- Classic mode, input {0,0,0,0,255,255,255,255} → output 127,127,127,127,255,255,255,255; out_last and done on the 8th pixel.
- Min-norm mode, same frame → output 0,0,0,0,255,255,255,255.
- Single-valued frame of all 100:
  - min-norm → eight 100s (identity path);
  - classic → eight 255s.
- Backpressure: out_ready toggling 1,0,1,0… plus randomly gapped in_valid → output sequence identical to the scoreboard; pixel held stable across stall cycles; in_ready=0 from the cycle after the 8th accept until S_CLR completes.
- Reset after 3 output pixels, then a new frame {10,20,30,40,50,60,70,80} in classic mode → out_valid=0 the cycle after reset; new output 31,63,95,127,159,191,223,255 (no stale histogram). A second back-to-back frame gives identical output.
